// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_seq_pkg
// Brief    : Shared types and step-word field layout for the PWM sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH0 = 2'd1,
        WAIT0  = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int DUTY_LSB = 0;
    localparam int DUTY_W   = 16;
    localparam int HOLD_LSB = 16;
    localparam int HOLD_W   = 16;

    typedef struct packed {
        logic [HOLD_W-1:0] hold;
        logic [DUTY_W-1:0] duty;
    } step_t;

    function automatic step_t unpack_step(input logic [31:0] word);
        step_t s;
        s.duty = word[DUTY_LSB +: DUTY_W];
        s.hold = word[HOLD_LSB +: HOLD_W];
        return s;
    endfunction

    // A hold of zero still plays the step once.
    function automatic logic [HOLD_W-1:0] hold_periods(input logic [HOLD_W-1:0] h);
        return (h == '0) ? HOLD_W'(1) : h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_seq_period_cnt.sv
`default_nettype none
// ============================================================================
// Module   : pwm_seq_period_cnt
// Brief    : PWM period counter and duty compare; pwm_out tracks the counter
//            value of the same cycle by comparing the next count to the next duty.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_seq_period_cnt
    import pwm_seq_pkg::*;
#(
    parameter int PERIOD = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_run_nxt,
    input  logic [DUTY_W-1:0] i_duty_nxt,
    output logic              o_pwm_out,
    output logic              o_period_end
);

    localparam logic [15:0] c_last = 16'(PERIOD - 1);

    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_pwm;

    assign o_period_end = (r_cnt == c_last);
    assign o_pwm_out    = r_pwm;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_en) begin
            w_cnt_nxt = o_period_end ? 16'd0 : r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_pwm <= i_run_nxt && (w_cnt_nxt < i_duty_nxt);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_seq_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pwm_seq_fetch
// Brief    : Fetches PWM step words from on-chip RAM (double-buffered) and
//            plays them gaplessly. Optional irq register: PWM_SEQ_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_seq_fetch
    import pwm_seq_pkg::*;
#(
    parameter int PERIOD = 1000,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              pwm_out,
    output logic              busy,
    output logic              irq,
    input  logic              irq_ack
);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_base, r_len, r_rd_ptr, r_remaining;
    logic [ADDR_W-1:0]   w_ptr, w_rem;
    logic [DUTY_W-1:0]   r_active_duty, w_duty_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    step_t               r_next, w_rd_step;
    logic                r_next_valid, r_next_wrap;
    logic                r_pend, r_pend_wrap;
    logic                r_stall, w_stall_nxt;
    logic                w_pf_req, w_req, w_run_en, w_adv, w_load, w_done;
    logic                w_period_end, w_run_nxt, w_start_go;

    assign w_rd_step  = unpack_step(mem_readdata);
    assign w_start_go = (r_state == IDLE) && start && !stop && (length != '0);

    // An exhausted pointer (loop enabled late) restarts the table from base.
    assign w_ptr    = (r_remaining == '0) ? r_base : r_rd_ptr;
    assign w_rem    = (r_remaining == '0) ? r_len  : r_remaining;
    assign w_pf_req = (r_state == RUN) && !r_next_valid && !r_pend &&
                      ((r_remaining != '0) || loop_en);
    assign w_req    = (r_state == FETCH0) || w_pf_req;

    assign mem_address    = w_req ? w_ptr : '0;
    assign mem_chipselect = w_req;
    assign mem_clken      = w_req;
    assign busy           = (r_state != IDLE);

    assign w_run_en = (r_state == RUN) && !r_stall;
    assign w_adv    = (w_run_en && w_period_end && (r_hold_cnt == HOLD_W'(1))) ||
                      ((r_state == RUN) && r_stall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall_nxt = r_stall;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall_nxt = 1'b0;
                if (start) begin
                    if (length != '0) begin
                        w_state_nxt = FETCH0;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            FETCH0: w_state_nxt = WAIT0;
            WAIT0: begin
                w_state_nxt = RUN;
                w_stall_nxt = 1'b0;
            end
            RUN: begin
                if (w_adv) begin
                    // A buffered word that starts a new pass only plays if looping is still on.
                    if (r_next_valid && !(r_next_wrap && !loop_en)) begin
                        w_load      = 1'b1;
                        w_stall_nxt = 1'b0;
                    end else if (r_next_valid ||
                                 (!r_pend && (r_remaining == '0) && !loop_en)) begin
                        w_state_nxt = IDLE;
                        w_stall_nxt = 1'b0;
                        w_done      = 1'b1;
                    end else begin
                        w_stall_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (stop) begin
            w_state_nxt = IDLE;
            w_stall_nxt = 1'b0;
            w_load      = 1'b0;
            w_done      = 1'b0;
        end
    end

    assign w_run_nxt  = (w_state_nxt == RUN) && !w_stall_nxt;
    assign w_duty_nxt = (r_state == WAIT0) ? w_rd_step.duty :
                        w_load             ? r_next.duty    : r_active_duty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base        <= '0;
            r_len         <= '0;
            r_rd_ptr      <= '0;
            r_remaining   <= '0;
            r_active_duty <= '0;
            r_hold_cnt    <= '0;
            r_next        <= '0;
            r_next_valid  <= 1'b0;
            r_next_wrap   <= 1'b0;
            r_pend        <= 1'b0;
            r_pend_wrap   <= 1'b0;
            r_stall       <= 1'b0;
        end else begin
            r_stall     <= w_stall_nxt;
            r_pend      <= w_pf_req;
            r_pend_wrap <= (r_remaining == '0) || (r_remaining == r_len);

            if (w_start_go) begin
                r_base      <= base_addr;
                r_len       <= length;
                r_rd_ptr    <= base_addr;
                r_remaining <= length;
            end else if (w_req) begin
                if ((w_rem == ADDR_W'(1)) && loop_en) begin
                    r_rd_ptr    <= r_base;
                    r_remaining <= r_len;
                end else begin
                    r_rd_ptr    <= w_ptr + ADDR_W'(1);
                    r_remaining <= w_rem - ADDR_W'(1);
                end
            end

            if (r_pend) begin
                r_next       <= w_rd_step;
                r_next_valid <= 1'b1;
                r_next_wrap  <= r_pend_wrap;
            end else if (w_load) begin
                r_next_valid <= 1'b0;
            end

            if ((r_state == WAIT0) && !stop) begin
                r_active_duty <= w_rd_step.duty;
                r_hold_cnt    <= hold_periods(w_rd_step.hold);
            end else if (w_load) begin
                r_active_duty <= r_next.duty;
                r_hold_cnt    <= hold_periods(r_next.hold);
            end else if (w_run_en && w_period_end && (r_hold_cnt != HOLD_W'(1))) begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end

            if (w_state_nxt == IDLE) begin
                r_next_valid <= 1'b0;
                r_pend       <= 1'b0;
            end
        end
    end

    pwm_seq_period_cnt #(
        .PERIOD (PERIOD)
    ) u_period_cnt (
        .clk          (clk),
        .rst          (reset),
        .i_en         (w_run_en),
        .i_clr        (r_state != RUN),
        .i_run_nxt    (w_run_nxt),
        .i_duty_nxt   (w_duty_nxt),
        .o_pwm_out    (pwm_out),
        .o_period_end (w_period_end)
    );

`ifdef PWM_SEQ_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else if (w_done) begin
            r_irq <= 1'b1;
        end else if (irq_ack) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq;

    assign w_unused_irq = irq_ack ^ w_done;
    assign irq          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_seq_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_seq_fetch
// Brief    : Self-checking bench for pwm_seq_fetch with a RAM model and a
//            step-list waveform reference.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_seq_fetch;

    localparam int PERIOD = 1000;
`ifdef PWM_SEQ_IRQ_EN
    localparam int c_irq_en = 1;
`else
    localparam int c_irq_en = 0;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        stop      = 1'b0;
    logic        loop_en   = 1'b0;
    logic        irq_ack   = 1'b0;
    logic [11:0] base_addr = '0;
    logic [11:0] length    = '0;
    logic [11:0] mem_address;
    logic        mem_chipselect, mem_clken;
    logic [31:0] mem_readdata;
    logic        pwm_out, busy, irq;

    logic [31:0] ram [4096];
    logic [11:0] req_addr [16];
    int          req_cnt = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        string       name;
        logic [11:0] base;
        logic [11:0] len;
        logic [31:0] w0, w1, w2;
        int          exp_busy;
        int          exp_reads;
    } vec_t;

    vec_t vecs [5];

    pwm_seq_fetch #(
        .PERIOD (PERIOD),
        .ADDR_W (12),
        .DATA_W (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .base_addr      (base_addr),
        .length         (length),
        .loop_en        (loop_en),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .pwm_out        (pwm_out),
        .busy           (busy),
        .irq            (irq),
        .irq_ack        (irq_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            mem_readdata          <= ram[mem_address];
            req_addr[req_cnt % 16] <= mem_address;
            req_cnt               <= req_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [11:0] base, input logic [11:0] len,
                                input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                                input int exp_busy, input int exp_reads);
        vec_t v;
        v.name = name; v.base = base; v.len = len;
        v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.exp_busy = exp_busy; v.exp_reads = exp_reads;
        return v;
    endfunction

    // Reference: expand the table into the per-cycle PWM level of each period.
    task automatic run_seq(input string name, input logic [11:0] base, input logic [11:0] len,
                           input bit loop, input int passes, input int clr_at,
                           input int exp_busy_in, input int exp_reads);
        bit          wave [$];
        logic [31:0] w;
        int          d, h, total, win, exp_busy, busy_cnt, errs, first_bad, r0, reads, addr_errs;
        bit          ep, eb;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < int'(len); i++) begin
                w = ram[12'(int'(base) + i)];
                d = int'(w[15:0]);
                h = int'(w[31:16]);
                if (h == 0) h = 1;
                for (int n = 0; n < h; n++)
                    for (int c = 0; c < PERIOD; c++)
                        wave.push_back(c < d);
            end
        end
        total     = wave.size();
        win       = (len == 0) ? 0 : 2 + total;
        exp_busy  = (exp_busy_in >= 0) ? exp_busy_in : win;
        busy_cnt  = 0;
        errs      = 0;
        first_bad = -1;
        r0        = req_cnt;
        @(negedge clk);
        base_addr = base; length = len; loop_en = loop; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < win + 3; k++) begin
            eb = (k < win);
            ep = (eb && k >= 2) ? wave[k-2] : 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (pwm_out !== ep || busy !== eb) begin
                errs++;
                if (first_bad < 0) first_bad = k;
            end
            if (k == clr_at) loop_en = 1'b0;
            @(negedge clk);
        end
        loop_en = 1'b0;
        check({name, " busy cycles"}, busy_cnt, exp_busy);
        check($sformatf("%s waveform errors (first bad cycle %0d)", name, first_bad), errs, 0);
        reads = req_cnt - r0;
        if (exp_reads >= 0) check({name, " read requests"}, reads, exp_reads);
        if (!loop) begin
            addr_errs = 0;
            for (int i = 0; i < reads && i < 16; i++)
                if (req_addr[(r0 + i) % 16] != 12'(int'(base) + i)) addr_errs++;
            check({name, " address order errors"}, addr_errs, 0);
        end
        check({name, " irq after done"}, int'(irq), c_irq_en);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check({name, " irq after ack"}, int'(irq), 0);
    endtask

    initial begin
        mem_readdata = '0;
        for (int i = 0; i < 4096; i++) ram[i] = '0;

        vecs[0] = mk("single", 12'h010, 12'd1, {16'd2, 16'd250}, 32'd0, 32'd0, 2002, 1);
        vecs[1] = mk("three",  12'h020, 12'd3, {16'd1, 16'd100}, {16'd1, 16'd500}, {16'd1, 16'd900}, 3002, 3);
        vecs[2] = mk("wrap",   12'hFFF, 12'd2, {16'd1, 16'd300}, {16'd1, 16'd700}, 32'd0, 2002, 2);
        vecs[3] = mk("hold0",  12'h100, 12'd2, {16'd0, 16'd0}, {16'd1, 16'd1200}, 32'd0, 2002, 2);
        vecs[4] = mk("len0",   12'h140, 12'd0, 32'd0, 32'd0, 32'd0, 0, 0);

        repeat (3) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset pwm_out", int'(pwm_out), 0);
        check("reset chipselect", int'(mem_chipselect), 0);
        check("reset irq", int'(irq), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            ram[vecs[v].base]          = vecs[v].w0;
            ram[vecs[v].base + 12'd1]  = vecs[v].w1;
            ram[vecs[v].base + 12'd2]  = vecs[v].w2;
            run_seq(vecs[v].name, vecs[v].base, vecs[v].len, 1'b0, 1, -1,
                    vecs[v].exp_busy, vecs[v].exp_reads);
        end

        // Loop A,B,A,B; looping is switched off midway through the second B.
        ram[12'h180] = {16'd1, 16'd200};
        ram[12'h181] = {16'd1, 16'd800};
        run_seq("loop", 12'h180, 12'd2, 1'b1, 2, 2 + 3 * PERIOD + PERIOD / 2, 4002, -1);

        for (int r = 0; r < 4; r++) begin
            logic [11:0] b;
            int          l;
            b = 12'($urandom_range(0, 4095));
            l = $urandom_range(1, 3);
            for (int i = 0; i < l; i++)
                ram[12'(int'(b) + i)] = {16'($urandom_range(0, 2)), 16'($urandom_range(0, 1100))};
            run_seq($sformatf("rand%0d", r), b, 12'(l), 1'b0, 1, -1, -1, l);
        end

        // Stop mid-period.
        ram[12'h200] = {16'd5, 16'd600};
        @(negedge clk);
        base_addr = 12'h200; length = 12'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        check("stop pre pwm_out", int'(pwm_out), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop pwm_out", int'(pwm_out), 0);
        check("stop busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        check("stop chipselect", int'(mem_chipselect), 0);
        check("stop irq", int'(irq), 0);

        // start and stop together.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("start+stop busy", int'(busy), 0);
        @(negedge clk);
        check("start+stop busy later", int'(busy), 0);

        // Asynchronous reset during RUN.
        ram[12'h300] = {16'd3, 16'd900};
        base_addr = 12'h300; length = 12'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("areset pre pwm_out", int'(pwm_out), 1);
        #2 reset = 1'b1;
        #1;
        check("areset pwm_out", int'(pwm_out), 0);
        check("areset busy", int'(busy), 0);
        check("areset chipselect", int'(mem_chipselect), 0);
        check("areset irq", int'(irq), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post areset busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
